// File: rtl/cmos_pkg.sv
// cmos_pkg: shared state encoding and default timing constants for the camera path.
package cmos_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, ARMED = 2'd2, RUN = 2'd3} state_t;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_SKIP_FRAMES = 10;
endpackage

// File: rtl/frame_rate_meter.sv
// frame_rate_meter: counts pulses over a CLK_FREQ-cycle window and reports a saturated total.
module frame_rate_meter
  import cmos_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int FPS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  output logic [FPS_W-1:0] fps,
  output logic             fps_update
);
  localparam int WIN_W = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_FREQ - 1);
  logic [WIN_W-1:0] win;
  logic [FPS_W-1:0] cnt;
  logic [FPS_W:0] sum;
  logic [FPS_W-1:0] sat;
  logic last;
  assign last = win == WIN_LAST;
  // a pulse on the terminal cycle still belongs to the closing window
  assign sum = {1'b0, cnt} + (FPS_W + 1)'(pulse);
  assign sat = sum[FPS_W] ? '1 : sum[FPS_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
      cnt <= '0;
      fps <= '0;
      fps_update <= 1'b0;
    end else begin
      win <= last ? '0 : win + WIN_W'(1);
      cnt <= last ? '0 : sat;
      fps_update <= last;
      if (last) fps <= sat;
    end
  end
endmodule

// File: rtl/cmos_frame_gate.sv
// cmos_frame_gate: skips settling frames after init, then opens frame-aligned capture windows.
module cmos_frame_gate
  import cmos_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
  parameter int FPS_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync_posedge,
  input  logic             init_done,
  input  logic             cap_en,
  output logic             frame_valid,
  output logic             frame_start,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [FPS_W-1:0] fps,
  output logic             fps_update
);
  localparam logic [7:0] SKIP_N = 8'(SKIP_FRAMES);
  state_t state, next;
  logic [7:0] skip_cnt;
  logic start_next;
  always_comb begin
    next = state;
    start_next = 1'b0;
    if (!init_done) next = IDLE;
    else
      case (state)
        IDLE: next = SKIP_N == 8'd0 ? ARMED : SKIP;
        SKIP: next = vsync_posedge && skip_cnt + 8'd1 == SKIP_N ? ARMED : SKIP;
        ARMED, RUN: begin
          next = vsync_posedge ? (cap_en ? RUN : ARMED) : state;
          start_next = vsync_posedge && cap_en;
        end
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      skip_cnt <= '0;
      frame_start <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= next;
      frame_start <= start_next;
      skip_cnt <= next != SKIP ? 8'd0 : state == SKIP && vsync_posedge ? skip_cnt + 8'd1 : skip_cnt;
      // frame count survives init loss and restarts only when capture is re-armed
      frame_cnt <= state == IDLE && init_done ? '0 : start_next ? frame_cnt + CNT_W'(1) : frame_cnt;
    end
  end
  assign frame_valid = state == RUN;
  frame_rate_meter #(.CLK_FREQ(CLK_FREQ), .FPS_W(FPS_W)) u_meter (
    .clk(clk),
    .rst_n(rst_n),
    .pulse(vsync_posedge),
    .fps(fps),
    .fps_update(fps_update)
  );
endmodule

// File: tb/tb_cmos_frame_gate.sv
// tb_cmos_frame_gate: directed scoreboard bench for gating, skip, stop, init loss, wrap, fps and async reset.
module tb_cmos_frame_gate;
  logic clk = 1'b0, rst_n = 1'b0;
  logic vs = 1'b0, init = 1'b0, cap = 1'b0;
  logic v2 = 1'b0, init2 = 1'b0, c2 = 1'b0;
  logic frame_valid, frame_start, fps_update;
  logic [15:0] frame_cnt;
  logic [7:0] fps;
  logic valid2, start2, upd2;
  logic [1:0] cnt2;
  logic [2:0] fps2;
  int checks = 0, failures = 0;
  int sb[$];
  int sb_exp;
  always #5 clk = ~clk;
  cmos_frame_gate #(.CLK_FREQ(100), .SKIP_FRAMES(3), .FPS_W(8), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .vsync_posedge(vs), .init_done(init), .cap_en(cap),
    .frame_valid(frame_valid), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .fps(fps), .fps_update(fps_update)
  );
  cmos_frame_gate #(.CLK_FREQ(100), .SKIP_FRAMES(0), .FPS_W(3), .CNT_W(2)) u_alt (
    .clk(clk), .rst_n(rst_n), .vsync_posedge(v2), .init_done(init2), .cap_en(c2),
    .frame_valid(valid2), .frame_start(start2), .frame_cnt(cnt2),
    .fps(fps2), .fps_update(upd2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input int gap);
    repeat (gap - 1) tick;
    vs = 1'b1;
    tick;
    vs = 1'b0;
  endtask
  // monitor: every start pulse must match the oldest expected frame count
  always @(negedge clk) begin
    if (rst_n && frame_start) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start actual=%0d required=none", frame_cnt);
      end else begin
        sb_exp = sb.pop_front();
        chk("start_cnt", 32'(frame_cnt), 32'(sb_exp));
        chk("start_valid", 32'(frame_valid), 1);
      end
    end
  end
  initial begin
    tick;
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_start", 32'(frame_start), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    chk("rst_fps", 32'(fps), 0);
    chk("rst_upd", 32'(fps_update), 0);
    chk("rst_alt_valid", 32'(valid2), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) tick;
    cap = 1'b1;
    init = 1'b1;
    tick;
    for (int k = 1; k <= 3; k++) begin
      frame(10);
      chk("skip_valid", 32'(frame_valid), 0);
    end
    sb.push_back(1);
    frame(10);
    chk("open_valid", 32'(frame_valid), 1);
    sb.push_back(2);
    frame(10);
    repeat (4) tick;
    cap = 1'b0;
    repeat (4) tick;
    chk("stop_midframe_valid", 32'(frame_valid), 1);
    frame(2);
    chk("stop_boundary_valid", 32'(frame_valid), 0);
    chk("stop_cnt_hold", 32'(frame_cnt), 2);
    frame(10);
    chk("armed_nocap_valid", 32'(frame_valid), 0);
    cap = 1'b1;
    sb.push_back(3);
    frame(10);
    chk("resume_valid", 32'(frame_valid), 1);
    repeat (4) tick;
    init = 1'b0;
    tick;
    chk("initloss_valid", 32'(frame_valid), 0);
    chk("initloss_cnt_hold", 32'(frame_cnt), 3);
    repeat (3) tick;
    init = 1'b1;
    tick;
    chk("rearm_cnt_clear", 32'(frame_cnt), 0);
    for (int k = 1; k <= 3; k++) begin
      frame(10);
      chk("reskip_valid", 32'(frame_valid), 0);
    end
    sb.push_back(1);
    frame(10);
    chk("reopen_valid", 32'(frame_valid), 1);
    sb.push_back(2);
    frame(10);
    tick;
    chk("pre_areset_valid", 32'(frame_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(frame_valid), 0);
    chk("areset_cnt", 32'(frame_cnt), 0);
    chk("areset_start", 32'(frame_start), 0);
    chk("areset_fps", 32'(fps), 0);
    chk("areset_upd", 32'(fps_update), 0);
    init = 1'b0;
    cap = 1'b0;
    repeat (2) tick;
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      vs = (e == 10 || e == 11 || e == 20 || e == 30 || e == 40 || e == 50 || e == 100);
      v2 = (e % 10 == 0 && e >= 20);
      tick;
      if (e == 1) begin
        chk("release_upd", 32'(fps_update), 0);
        chk("release_start", 32'(frame_start), 0);
      end
      if (e == 99) chk("fps_upd_early", 32'(fps_update), 0);
    end
    vs = 1'b0;
    v2 = 1'b0;
    chk("fps_value", 32'(fps), 7);
    chk("fps_upd", 32'(fps_update), 1);
    chk("fps_sat_value", 32'(fps2), 7);
    chk("fps_sat_upd", 32'(upd2), 1);
    tick;
    chk("fps_upd_once", 32'(fps_update), 0);
    init2 = 1'b1;
    c2 = 1'b1;
    repeat (2) tick;
    chk("zero_skip_armed_valid", 32'(valid2), 0);
    for (int k = 1; k <= 5; k++) begin
      v2 = 1'b1;
      tick;
      v2 = 1'b0;
      chk("zero_skip_valid", 32'(valid2), 1);
      chk("zero_skip_start", 32'(start2), 1);
      chk("wrap_cnt", 32'(cnt2), 32'(k % 4));
      tick;
      chk("zero_skip_start_end", 32'(start2), 0);
    end
    repeat (3) tick;
    chk("sb_drain", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
